hazard_ctrl: RTL and testbench

Pipeline hazard and fetch-sequencing controller for the 5-stage MIPS pipeline. It drives the fetch stage's `PCWrite`, `PCSrc` and `jump` inputs, plus the IF/ID and ID/EX write and flush controls. It resolves load-use stalls, branch and jump redirects, external memory-wait freezes, and halt/resume. Optional saturating performance counters record stall and flush activity.

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and fetch-sequencing controller for the 5-stage MIPS pipeline.
// Resolves load-use stalls, branch/jump redirects, memory-wait freezes and halt/resume.
// Optional build macro: HAZARD_PERF_CNT_EN enables the saturating stall/flush counters;
// without it stall_cnt/flush_cnt are tied to 0.
//
// state | meaning
// RUN   | normal issue, hazard priority evaluated every cycle
// WAIT  | pipeline frozen while mem_busy is high
// HALT  | halt instruction retired into ID, waiting for resume

module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             jump,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             stall_all,
  output logic             halted,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  // Wait counter saturates one past WAIT_MAX, which is enough to flag the overrun.
  localparam int WCNT_W = $clog2(WAIT_MAX + 2);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WCNT_SAT = WCNT_W'(WAIT_MAX + 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lu;
  logic              lu_bubble;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_use_rs && (ex_rt == id_rs)) || (id_use_rt && (ex_rt == id_rt)));

  // State register; reset aborts any WAIT or HALT back to RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Next state and control outputs; WAIT with mem_busy low falls through to the RUN rules.
  always_comb begin
    state_nxt  = state;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    jump       = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_all  = 1'b0;
    halted     = 1'b0;
    lu_bubble  = 1'b0;
    case (state)
      S_HALT: begin
        idex_flush = 1'b1;
        halted     = 1'b1;
        if (resume) state_nxt = S_RUN;
      end
      default: begin
        if (mem_busy) begin
          stall_all = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_RUN;
          if (ex_branch_taken) begin
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            idex_flush = 1'b1;
            lu_bubble  = 1'b1;
          end else if (id_halt) begin
            idex_flush = 1'b1;
            state_nxt  = S_HALT;
          end else if (id_jump) begin
            jump       = 1'b1;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            PCWrite    = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end
    endcase
    if (reset) begin
      state_nxt  = S_RUN;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      jump       = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      stall_all  = 1'b0;
      halted     = 1'b0;
      lu_bubble  = 1'b0;
    end
  end

  // Consecutive frozen-cycle counter with sticky overrun flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else begin
      if (stall_all) begin
        if (wait_cnt != WCNT_SAT) wait_cnt <= wait_cnt + WCNT_W'(1);
        if (wait_cnt >= WCNT_MAX) wait_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_evt = lu_bubble | stall_all | halted;
  assign flush_evt = PCSrc | jump;

  // Saturating stall and redirect counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_lu_bubble;
  assign unused_lu_bubble = lu_bubble;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario tasks plus randomized traffic against a cycle-level model of
// the hazard rules (halted / frozen / priority decision), not of the RTL state machine.

module tb_hazard_ctrl;

  localparam int TB_CNT_W   = 4;
  localparam int TB_WAIT    = 15;
  localparam int CNT_LIMIT  = (1 << TB_CNT_W) - 1;

  // {PCWrite, PCSrc, jump, ifid_write, ifid_flush, idex_flush, stall_all, halted}
  localparam logic [7:0] V_RESET  = 8'b0000_1100;
  localparam logic [7:0] V_NORMAL = 8'b1001_0000;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_use_rs, id_use_rt, id_jump, id_halt, ex_mem_read, ex_branch_taken, mem_busy, resume;
  logic PCWrite, PCSrc, jump, ifid_write, ifid_flush, idex_flush, stall_all, halted, wait_timeout;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctrl;

  int errors = 0;
  int checks = 0;

  bit m_halt;
  int m_frozen;
  bit m_timeout;
  int m_stall;
  int m_flush;

  hazard_ctrl #(.CNT_W(TB_CNT_W), .WAIT_MAX(TB_WAIT)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump), .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .resume(resume),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .jump(jump), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .stall_all(stall_all),
    .halted(halted), .wait_timeout(wait_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {PCWrite, PCSrc, jump, ifid_write, ifid_flush, idex_flush, stall_all, halted};

  always #5 clock = ~clock;

  function automatic bit model_lu();
    return ex_mem_read && (ex_rt != 0) &&
           ((id_use_rs && ex_rt == id_rs) || (id_use_rt && ex_rt == id_rt));
  endfunction

  function automatic logic [7:0] exp_ctrl();
    if (m_halt)          return 8'b0000_0101;
    if (mem_busy)        return 8'b0000_0010;
    if (ex_branch_taken) return 8'b1100_1100;
    if (model_lu())      return 8'b0000_0100;
    if (id_halt)         return 8'b0000_0100;
    if (id_jump)         return 8'b1010_1000;
    return V_NORMAL;
  endfunction

  function automatic logic [TB_CNT_W-1:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
    return TB_CNT_W'(m_stall);
`else
    return '0;
`endif
  endfunction

  function automatic logic [TB_CNT_W-1:0] exp_flush();
`ifdef HAZARD_PERF_CNT_EN
    return TB_CNT_W'(m_flush);
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_halt = 0; m_frozen = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_use_rs = 0; id_use_rt = 0; id_jump = 0;
    id_halt = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0; resume = 0;
  endtask

  // Advance one clock edge and apply the rules to the model with the inputs held this cycle.
  task automatic step();
    bit lu, frz, run;
    @(posedge clock);
    lu  = model_lu();
    frz = !m_halt && mem_busy;
    run = !m_halt && !mem_busy;
    if (m_halt || frz || (run && !ex_branch_taken && lu))
      if (m_stall < CNT_LIMIT) m_stall++;
    if (run && (ex_branch_taken || (!lu && !id_halt && id_jump)))
      if (m_flush < CNT_LIMIT) m_flush++;
    if (frz) m_frozen++; else m_frozen = 0;
    if (m_frozen > TB_WAIT) m_timeout = 1;
    if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (run && !ex_branch_taken && !lu && id_halt) begin
      m_halt = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== V_RESET) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, V_RESET); end
    checks++;
    if (wait_timeout !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL reset_regs got=%b/%0d/%0d want=0/0/0", wait_timeout, stall_cnt, flush_cnt);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_no_hazard();
    clear_in();
    for (int i = 0; i < 5; i++) begin
      #4;
      checks++;
      if (ctrl !== V_NORMAL) begin errors++; $display("FAIL nohaz_ctrl cyc=%0d got=%b want=%b", i, ctrl, V_NORMAL); end
      step();
    end
    checks++;
    if (stall_cnt !== '0) begin errors++; $display("FAIL nohaz_stall got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    clear_in();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1;
    #4;
    checks++;
    if (ctrl !== 8'b0000_0100) begin errors++; $display("FAIL lu_bubble got=%b want=%b", ctrl, 8'b0000_0100); end
    step();
    clear_in();
    #4;
    checks++;
    if (ctrl !== V_NORMAL) begin errors++; $display("FAIL lu_after got=%b want=%b", ctrl, V_NORMAL); end
    checks++;
    if (stall_cnt !== exp_stall()) begin errors++; $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall()); end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== TB_CNT_W'(1)) begin errors++; $display("FAIL lu_stall_one got=%0d want=1", stall_cnt); end
`endif
    step();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_use_rs = 1;
    #4;
    checks++;
    if (ctrl !== V_NORMAL) begin errors++; $display("FAIL lu_r0 got=%b want=%b", ctrl, V_NORMAL); end
    step();
    clear_in();
    ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_use_rt = 1; id_jump = 1;
    #4;
    checks++;
    if (ctrl !== 8'b0000_0100) begin errors++; $display("FAIL lu_over_jump got=%b want=%b", ctrl, 8'b0000_0100); end
    step();
    ex_mem_read = 0;
    #4;
    checks++;
    if (ctrl !== 8'b1010_1000) begin errors++; $display("FAIL jump_retry got=%b want=%b", ctrl, 8'b1010_1000); end
    step();
    clear_in();
  endtask

  task automatic test_branch_priority();
    int f0;
    clear_in();
    f0 = m_flush;
    ex_branch_taken = 1; id_jump = 1; id_halt = 1;
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_use_rs = 1;
    #4;
    checks++;
    if (ctrl !== 8'b1100_1100) begin errors++; $display("FAIL branch_ctrl got=%b want=%b", ctrl, 8'b1100_1100); end
    step();
    clear_in();
    #4;
    checks++;
    if (ctrl !== V_NORMAL) begin errors++; $display("FAIL branch_no_halt got=%b want=%b", ctrl, V_NORMAL); end
    checks++;
    if (flush_cnt !== exp_flush()) begin errors++; $display("FAIL branch_flush_cnt got=%0d want=%0d", flush_cnt, exp_flush()); end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (m_flush != f0 + 1) begin errors++; $display("FAIL branch_flush_step got=%0d want=%0d", m_flush, f0 + 1); end
`endif
    step();
  endtask

  task automatic test_mem_wait();
    clear_in();
    mem_busy = 1; ex_branch_taken = 1;
    for (int i = 1; i <= 20; i++) begin
      #4;
      checks++;
      if (ctrl !== 8'b0000_0010) begin errors++; $display("FAIL wait_ctrl cyc=%0d got=%b want=%b", i, ctrl, 8'b0000_0010); end
      if (i == 16 || i == 17) begin
        checks++;
        if (wait_timeout !== (i == 17)) begin
          errors++; $display("FAIL wait_timeout_edge cyc=%0d got=%b want=%b", i, wait_timeout, i == 17);
        end
      end
      step();
    end
    mem_busy = 0;
    #4;
    checks++;
    if (ctrl !== 8'b1100_1100) begin errors++; $display("FAIL wait_deferred_branch got=%b want=%b", ctrl, 8'b1100_1100); end
    step();
    clear_in();
    repeat (3) begin
      #4;
      checks++;
      if (wait_timeout !== 1'b1) begin errors++; $display("FAIL wait_timeout_sticky got=%b want=1", wait_timeout); end
      step();
    end
  endtask

  task automatic test_halt();
    clear_in();
    id_halt = 1;
    #4;
    checks++;
    if (ctrl !== 8'b0000_0100) begin errors++; $display("FAIL halt_entry got=%b want=%b", ctrl, 8'b0000_0100); end
    step();
    clear_in();
    for (int i = 0; i < 10; i++) begin
      mem_busy = (i % 3 == 0);
      id_jump = 1;
      #4;
      checks++;
      if (ctrl !== 8'b0000_0101) begin errors++; $display("FAIL halt_hold cyc=%0d got=%b want=%b", i, ctrl, 8'b0000_0101); end
      step();
    end
    clear_in();
    resume = 1;
    #4;
    checks++;
    if (ctrl !== 8'b0000_0101) begin errors++; $display("FAIL halt_resume_cyc got=%b want=%b", ctrl, 8'b0000_0101); end
    step();
    resume = 0;
    #4;
    checks++;
    if (ctrl !== V_NORMAL) begin errors++; $display("FAIL halt_after_resume got=%b want=%b", ctrl, V_NORMAL); end
    checks++;
    if (stall_cnt !== exp_stall()) begin errors++; $display("FAIL halt_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall()); end
    step();
  endtask

  task automatic test_reset_in_halt();
    clear_in();
    id_halt = 1;
    step();
    clear_in();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== V_RESET) begin errors++; $display("FAIL rst_halt_ctrl got=%b want=%b", ctrl, V_RESET); end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #4;
    checks++;
    if (ctrl !== V_NORMAL) begin errors++; $display("FAIL rst_halt_run got=%b want=%b", ctrl, V_NORMAL); end
    checks++;
    if (wait_timeout !== 1'b0) begin errors++; $display("FAIL rst_halt_timeout got=%b want=0", wait_timeout); end
    step();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 400; i++) begin
      mem_busy        = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_jump         = ($urandom_range(0, 4) == 0);
      id_halt         = ($urandom_range(0, 11) == 0);
      resume          = ($urandom_range(0, 3) == 0);
      ex_mem_read     = $urandom_range(0, 1);
      ex_rt           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_use_rs       = $urandom_range(0, 1);
      id_use_rt       = $urandom_range(0, 1);
      #4;
      e = exp_ctrl();
      checks++;
      if (ctrl !== e) begin errors++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", i, ctrl, e); end
      checks++;
      if (wait_timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout cyc=%0d got=%b want=%b", i, wait_timeout, m_timeout); end
      checks++;
      if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
        errors++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall(), exp_flush());
      end
      step();
    end
    clear_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_hazard();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_reset();
    test_halt();
    test_reset_in_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
